// File: rtl/alu_share_arb_if.sv
// Bus bundle between the two ALU requesters, the shared ALU and the response consumer.
// The arbiter uses the slave view; requesters, ALU and consumer use the master view.
interface alu_share_arb_if #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int FLAG_W  = 5,
    parameter int CNT_W   = 16
);
    logic               req0_valid;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_op1;
    logic [DATA_W-1:0]  req0_op2;
    logic [FUNCT_W-1:0] req0_funct;

    logic               req1_valid;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_op1;
    logic [DATA_W-1:0]  req1_op2;
    logic [FUNCT_W-1:0] req1_funct;

    logic [DATA_W-1:0]  alu_op1;
    logic [DATA_W-1:0]  alu_op2;
    logic [FUNCT_W-1:0] alu_funct;
    logic [DATA_W:0]    alu_res;
    logic [FLAG_W-1:0]  alu_flags;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W:0]    rsp_res;
    logic [FLAG_W-1:0]  rsp_flags;
    logic               rsp_id;

    logic [CNT_W-1:0]   stat_grant0;
    logic [CNT_W-1:0]   stat_grant1;
    logic [CNT_W-1:0]   stat_conflict;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_funct,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2, req1_funct,
        output req1_ready,
        output alu_op1, alu_op2, alu_funct,
        input  alu_res, alu_flags,
        output rsp_valid, rsp_res, rsp_flags, rsp_id,
        input  rsp_ready,
        output stat_grant0, stat_grant1, stat_conflict
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_funct,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2, req1_funct,
        input  req1_ready,
        input  alu_op1, alu_op2, alu_funct,
        output alu_res, alu_flags,
        input  rsp_valid, rsp_res, rsp_flags, rsp_id,
        output rsp_ready,
        input  stat_grant0, stat_grant1, stat_conflict
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer for the shared ALU: grant, register operands, capture result, hold response.
// Optional grant/conflict statistics counters are enabled with macro ALU_ARB_STATS_EN.
//
//   state  | meaning
//   IDLE   | waiting for a request; grant computed combinationally
//   EXEC   | ALU evaluating registered operands; result captured at the edge
//   RESP   | response held until rsp_ready
module alu_share_arb #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int FLAG_W  = 5,
    parameter int CNT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    alu_share_arb_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               id_q, id_d;
    logic [DATA_W-1:0]  alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0]  alu_op2_q, alu_op2_d;
    logic [FUNCT_W-1:0] alu_funct_q, alu_funct_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W:0]    rsp_res_q, rsp_res_d;
    logic [FLAG_W-1:0]  rsp_flags_q, rsp_flags_d;
    logic               rsp_id_q, rsp_id_d;

    logic grant0, grant1;
    logic ready0, ready1;
    logic hs0, hs1;

    // With both valid, the requester that did not win last time is granted.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    assign ready0 = !rst && (state_q == S_IDLE) && grant0;
    assign ready1 = !rst && (state_q == S_IDLE) && grant1;
    assign hs0    = ready0 && bus.req0_valid;
    assign hs1    = ready1 && bus.req1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_funct_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_res_q    <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_funct_q  <= alu_funct_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_res_q    <= rsp_res_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_funct_d  = alu_funct_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_res_d    = rsp_res_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            S_IDLE: begin
                if (hs0) begin
                    alu_op1_d    = bus.req0_op1;
                    alu_op2_d    = bus.req0_op2;
                    alu_funct_d  = bus.req0_funct;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_EXEC;
                end else if (hs1) begin
                    alu_op1_d    = bus.req1_op1;
                    alu_op2_d    = bus.req1_op2;
                    alu_funct_d  = bus.req1_funct;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_res_d   = bus.alu_res;
                rsp_flags_d = bus.alu_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_op1    = alu_op1_q;
    assign bus.alu_op2    = alu_op2_q;
    assign bus.alu_funct  = alu_funct_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_res    = rsp_res_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_id     = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] stat_grant0_q, stat_grant0_d;
    logic [CNT_W-1:0] stat_grant1_q, stat_grant1_d;
    logic [CNT_W-1:0] stat_conflict_q, stat_conflict_d;

    always_comb begin
        stat_grant0_d   = stat_grant0_q;
        stat_grant1_d   = stat_grant1_q;
        stat_conflict_d = stat_conflict_q;
        if (hs0) begin
            stat_grant0_d = stat_grant0_q + CNT_W'(1);
        end
        if (hs1) begin
            stat_grant1_d = stat_grant1_q + CNT_W'(1);
        end
        if ((state_q == S_IDLE) && bus.req0_valid && bus.req1_valid) begin
            stat_conflict_d = stat_conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign bus.stat_grant0   = stat_grant0_q;
    assign bus.stat_grant1   = stat_grant1_q;
    assign bus.stat_conflict = stat_conflict_q;
`else
    assign bus.stat_grant0   = '0;
    assign bus.stat_grant1   = '0;
    assign bus.stat_conflict = '0;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU on the alu_* side.
// Define ALU_ARB_STATS_EN to check counters with CNT_W = 2.
module tb_alu_share_arb;
    localparam int DATA_W  = 32;
    localparam int FUNCT_W = 6;
    localparam int FLAG_W  = 5;
`ifdef ALU_ARB_STATS_EN
    localparam int CNT_W   = 2;
    localparam bit STATS   = 1'b1;
`else
    localparam int CNT_W   = 16;
    localparam bit STATS   = 1'b0;
`endif

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h01;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h02;
    localparam int FL_ZERO  = 0;
    localparam int FL_NEG   = 1;
    localparam int FL_CARRY = 2;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_share_arb_if #(.DATA_W(DATA_W), .FUNCT_W(FUNCT_W), .FLAG_W(FLAG_W), .CNT_W(CNT_W)) bus ();

    alu_share_arb #(.DATA_W(DATA_W), .FUNCT_W(FUNCT_W), .FLAG_W(FLAG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 33-bit add/sub with carry/borrow in bit 32.
    logic [DATA_W:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (bus.alu_funct)
            FN_ADD:  alu_sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
            FN_SUB:  alu_sum = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
            default: alu_sum = '0;
        endcase
        bus.alu_res             = alu_sum;
        bus.alu_flags           = '0;
        bus.alu_flags[FL_ZERO]  = (alu_sum[DATA_W-1:0] == '0);
        bus.alu_flags[FL_NEG]   = alu_sum[DATA_W-1];
        bus.alu_flags[FL_CARRY] = alu_sum[DATA_W];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [FUNCT_W-1:0] f,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.req0_valid = v;
        bus.req0_funct = f;
        bus.req0_op1   = a;
        bus.req0_op2   = b;
    endtask

    task automatic drive1(input logic v, input logic [FUNCT_W-1:0] f,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.req1_valid = v;
        bus.req1_funct = f;
        bus.req1_op1   = a;
        bus.req1_op2   = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive0(1'b1, FN_ADD, 32'd5, 32'd7);
        drive1(1'b0, '0, '0, '0);

        // Reset state; ready must stay low while rst is high.
        cyc();
        cyc();
        chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_alu_op1", 64'(bus.alu_op1), 64'd0);
        chk("rst_alu_funct", 64'(bus.alu_funct), 64'd0);
        chk("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_stat_g0", 64'(bus.stat_grant0), 64'd0);

        // Single add from req0.
        rst = 1'b0;
        #1;
        chk("add_ready0", 64'(bus.req0_ready), 64'd1);
        chk("add_ready1", 64'(bus.req1_ready), 64'd0);
        cyc();
        drive0(1'b0, '0, '0, '0);
        chk("add_alu_op1", 64'(bus.alu_op1), 64'd5);
        chk("add_alu_op2", 64'(bus.alu_op2), 64'd7);
        chk("add_alu_funct", 64'(bus.alu_funct), 64'(FN_ADD));
        chk("add_exec_valid", 64'(bus.rsp_valid), 64'd0);
        cyc();
        chk("add_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("add_rsp_res", 64'(bus.rsp_res), 64'd12);
        chk("add_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("add_rsp_id", 64'(bus.rsp_id), 64'd0);
        cyc();
        chk("add_rsp_done", 64'(bus.rsp_valid), 64'd0);

        // Carry case from req1; granting it proves the FSM is back in IDLE.
        drive1(1'b1, FN_ADD, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("carry_ready1", 64'(bus.req1_ready), 64'd1);
        chk("carry_ready0", 64'(bus.req0_ready), 64'd0);
        cyc();
        drive1(1'b0, '0, '0, '0);
        cyc();
        chk("carry_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("carry_rsp_res", 64'(bus.rsp_res), 64'h1_0000_0000);
        chk("carry_rsp_flags", 64'(bus.rsp_flags), 64'b00101);
        chk("carry_rsp_id", 64'(bus.rsp_id), 64'd1);
        cyc();

        // Backpressure: response held for 4 cycles with both requesters pending.
        bus.rsp_ready = 1'b0;
        drive0(1'b1, FN_ADD, 32'd9, 32'd4);
        #1;
        chk("bp_ready0", 64'(bus.req0_ready), 64'd1);
        cyc();
        drive0(1'b1, FN_SUB, 32'd100, 32'd1);
        drive1(1'b1, FN_ADD, 32'd50, 32'd50);
        #1;
        chk("bp_exec_ready0", 64'(bus.req0_ready), 64'd0);
        chk("bp_exec_ready1", 64'(bus.req1_ready), 64'd0);
        cyc();
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("bp_hold_valid_%0d", i), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("bp_hold_res_%0d", i), 64'(bus.rsp_res), 64'd13);
            chk($sformatf("bp_hold_flags_%0d", i), 64'(bus.rsp_flags), 64'd0);
            chk($sformatf("bp_hold_id_%0d", i), 64'(bus.rsp_id), 64'd0);
            chk($sformatf("bp_hold_r0_%0d", i), 64'(bus.req0_ready), 64'd0);
            chk($sformatf("bp_hold_r1_%0d", i), 64'(bus.req1_ready), 64'd0);
        end
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b1;
        cyc();
        chk("bp_release", 64'(bus.rsp_valid), 64'd0);
        cyc();
        chk("bp_single_rsp", 64'(bus.rsp_valid), 64'd0);

        // Arbitration after a fresh reset: both valid continuously.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive0(1'b1, FN_SUB, 32'd3, 32'd5);
        drive1(1'b1, FN_ADD, 32'd1, 32'd1);
        #1;
        chk("arb1_ready0", 64'(bus.req0_ready), 64'd1);
        chk("arb1_ready1", 64'(bus.req1_ready), 64'd0);
        cyc();
        cyc();
        chk("arb1_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("arb1_rsp_res", 64'(bus.rsp_res[31:0]), 64'hFFFF_FFFE);
        chk("arb1_rsp_neg", 64'(bus.rsp_flags[FL_NEG]), 64'd1);
        cyc();
        chk("arb2_ready1", 64'(bus.req1_ready), 64'd1);
        chk("arb2_ready0", 64'(bus.req0_ready), 64'd0);
        cyc();
        cyc();
        chk("arb2_rsp_id", 64'(bus.rsp_id), 64'd1);
        chk("arb2_rsp_res", 64'(bus.rsp_res), 64'd2);
        cyc();
        chk("arb3_ready0", 64'(bus.req0_ready), 64'd1);
        chk("arb3_ready1", 64'(bus.req1_ready), 64'd0);
        cyc();
        chk("arb_stat_conflict", 64'(bus.stat_conflict), STATS ? 64'd3 : 64'd0);
        chk("arb_stat_g0", 64'(bus.stat_grant0), STATS ? 64'd2 : 64'd0);
        chk("arb_stat_g1", 64'(bus.stat_grant1), STATS ? 64'd1 : 64'd0);
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        cyc();
        chk("arb3_rsp_id", 64'(bus.rsp_id), 64'd0);
        cyc();

        // Reset in EXEC: op discarded, last_grant back to 1.
        drive0(1'b1, FN_ADD, 32'd2, 32'd2);
        #1;
        chk("mid_ready0", 64'(bus.req0_ready), 64'd1);
        cyc();
        drive0(1'b0, '0, '0, '0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("mid_no_rsp_%0d", i), 64'(bus.rsp_valid), 64'd0);
        end
        drive0(1'b1, FN_ADD, 32'd1, 32'd2);
        drive1(1'b1, FN_ADD, 32'd3, 32'd4);
        #1;
        chk("mid_after_ready0", 64'(bus.req0_ready), 64'd1);
        chk("mid_after_ready1", 64'(bus.req1_ready), 64'd0);
        cyc();
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        cyc();
        chk("mid_after_res", 64'(bus.rsp_res), 64'd3);
        cyc();

        // Counter wrap: five req0 grants after reset.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, FN_ADD, 32'(i), 32'd1);
            cyc();
            drive0(1'b0, '0, '0, '0);
            cyc();
            cyc();
        end
        chk("wrap_stat_g0", 64'(bus.stat_grant0), STATS ? 64'd1 : 64'd0);
        chk("wrap_stat_g1", 64'(bus.stat_grant1), 64'd0);
        chk("wrap_stat_conflict", 64'(bus.stat_conflict), 64'd0);
        chk("wrap_last_res", 64'(bus.rsp_res), 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
